// File: rtl/arm_lp_pkg.sv
// Shared definitions for the ARM-LP execute/memory core.
// Holds the opcode constants, the op_type encodings, the ALU control codes
// and the packed bundle of decoded control flags.
package arm_lp_pkg;

  // Full 11-bit opcodes, instr[31:21]
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  // Shorter opcodes, compared against the upper bits of the instruction only
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;  // instr[31:22]
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;  // instr[31:22]
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;     // instr[31:24]
  localparam logic [5:0]  OP_B    = 6'b000101;       // instr[31:26]

  typedef enum logic [2:0] {
    OPT_R   = 3'd0,
    OPT_I   = 3'd1,
    OPT_D   = 3'd2,
    OPT_B   = 3'd3,
    OPT_CB  = 3'd4,
    OPT_INV = 3'd7
  } op_type_e;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_ORR  = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0110,
    ALU_PASS = 4'b0111,
    ALU_NOR  = 4'b1100
  } alu_ctl_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic branch;
    logic uncond_branch;
    logic alu_src;
  } ctrl_t;

endpackage

// File: rtl/arm_lp_dcache.sv
// Data cache with its stage-2 control registers (captured at E1, used at E2).
// Ports:
//   clock, reset_n           processor clock, async active-low reset
//   mem_read, mem_write, mem_to_reg  decoded flags of the instruction in E1
//   store_data               write data for the instruction in E1
//   alu_result               registered ALU result (address / pass-through)
//   read_data                registered write-back value
module arm_lp_dcache #(
  parameter int ADDR_BITS = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_to_reg,
  input  logic [31:0] store_data,
  input  logic [31:0] alu_result,
  output logic [31:0] read_data
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [31:0]          mem [DEPTH];
  logic                 mem_read_s2, mem_write_s2, mem_to_reg_s2;
  logic [31:0]          store_data_s2;
  logic [ADDR_BITS-1:0] index;
  logic [31:0]          load_word;

  // Word-addressed: byte offset and bits above the cache size are ignored.
  assign index     = alu_result[ADDR_BITS+1:2];
  assign load_word = mem_read_s2 ? mem[index] : 32'd0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_read_s2   <= 1'b0;
      mem_write_s2  <= 1'b0;
      mem_to_reg_s2 <= 1'b0;
      store_data_s2 <= '0;
      read_data     <= '0;
      // NOTE: the array is cleared on reset so a load after reset returns 0;
      // this makes it a register file rather than an inferred RAM macro.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      mem_read_s2   <= mem_read;
      mem_write_s2  <= mem_write;
      mem_to_reg_s2 <= mem_to_reg;
      store_data_s2 <= store_data;
      if (mem_write_s2) mem[index] <= store_data_s2;
      // A same-edge read of the written word would see the old contents;
      // serialized stages mean a load never shares an edge with a store.
      read_data <= mem_to_reg_s2 ? load_word : alu_result;
    end
  end

endmodule

// File: rtl/arm_lp_decoder.sv
// Instruction decoder with its output register (pipeline edge E0).
// Ports:
//   clock, reset_n            processor clock, async active-low reset
//   instruction               32-bit instruction from the instruction cache
//   reg_write .. alu_src      registered control flags
//   op_type                   registered instruction class (7 = invalid)
//   alu_control_code          registered ALU operation
//   read_register1/2, write_register  registered register IDs
module arm_lp_decoder
  import arm_lp_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] instruction,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        branch,
  output logic        uncond_branch,
  output logic        alu_src,
  output logic [2:0]  op_type,
  output logic [3:0]  alu_control_code,
  output logic [4:0]  read_register1,
  output logic [4:0]  read_register2,
  output logic [4:0]  write_register
);

  logic [10:0] opcode;
  ctrl_t       ctrl_d, ctrl_q;
  op_type_e    op_d;
  alu_ctl_e    ctl_d;
  logic [4:0]  rr1_d, rr2_d, wr_d;

  assign opcode = instruction[31:21];

  // Immediate/offset fields are consumed by operand prep, not here.
  logic unused_imm;
  assign unused_imm = ^instruction[15:10];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    ctrl_d = '0;
    op_d   = OPT_INV;
    ctl_d  = ALU_AND;
    rr2_d  = '0;
    if (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_AND || opcode == OP_ORR) begin
      op_d             = OPT_R;
      ctrl_d.reg_write = 1'b1;
      rr2_d            = instruction[20:16];
      case (opcode)
        OP_SUB:  ctl_d = ALU_SUB;
        OP_AND:  ctl_d = ALU_AND;
        OP_ORR:  ctl_d = ALU_ORR;
        default: ctl_d = ALU_ADD;
      endcase
    end else if (instruction[31:22] == OP_ADDI || instruction[31:22] == OP_SUBI) begin
      op_d             = OPT_I;
      ctrl_d.reg_write = 1'b1;
      ctrl_d.alu_src   = 1'b1;
      ctl_d            = (instruction[31:22] == OP_SUBI) ? ALU_SUB : ALU_ADD;
    end else if (opcode == OP_LDUR) begin
      op_d              = OPT_D;
      ctrl_d.reg_write  = 1'b1;
      ctrl_d.mem_read   = 1'b1;
      ctrl_d.mem_to_reg = 1'b1;
      ctrl_d.alu_src    = 1'b1;
      ctl_d             = ALU_ADD;
    end else if (opcode == OP_STUR) begin
      op_d             = OPT_D;
      ctrl_d.mem_write = 1'b1;
      ctrl_d.alu_src   = 1'b1;
      ctl_d            = ALU_ADD;
      rr2_d            = instruction[4:0];  // Rt is the value to store
    end else if (instruction[31:24] == OP_CBZ) begin
      op_d          = OPT_CB;
      ctrl_d.branch = 1'b1;
      ctl_d         = ALU_PASS;
      rr2_d         = instruction[4:0];     // Rt is the value tested for zero
    end else if (instruction[31:26] == OP_B) begin
      op_d                 = OPT_B;
      ctrl_d.uncond_branch = 1'b1;
    end
    // Unknown opcodes report no register IDs at all.
    rr1_d = (op_d != OPT_INV) ? instruction[9:5] : 5'd0;
    wr_d  = (op_d != OPT_INV) ? instruction[4:0] : 5'd0;
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples its inputs from before the edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q           <= '0;
      op_type          <= '0;
      alu_control_code <= '0;
      read_register1   <= '0;
      read_register2   <= '0;
      write_register   <= '0;
    end else begin
      ctrl_q           <= ctrl_d;
      op_type          <= op_d;
      alu_control_code <= ctl_d;
      read_register1   <= rr1_d;
      read_register2   <= rr2_d;
      write_register   <= wr_d;
    end
  end

  assign reg_write     = ctrl_q.reg_write;
  assign mem_read      = ctrl_q.mem_read;
  assign mem_write     = ctrl_q.mem_write;
  assign mem_to_reg    = ctrl_q.mem_to_reg;
  assign branch        = ctrl_q.branch;
  assign uncond_branch = ctrl_q.uncond_branch;
  assign alu_src       = ctrl_q.alu_src;

endmodule

// File: rtl/arm_lp_exec_core.sv
// ARM-LP execute/memory core: decode (E0), ALU (E1), data cache and
// write-back (E2). One instruction per clock, no stalls.
// Ports:
//   clock, reset_n                  processor clock, async active-low reset
//   instruction                     instruction from the instruction cache
//   read_data1, read_data2          ALU operands A and B from operand prep
//   store_data                      data-cache write data (Rt value)
//   reg_write .. alu_src, op_type, alu_control_code, register IDs  decode
//   alu_result, zero_flag, carry_bit  registered ALU outputs
//   read_data                       registered write-back value
module arm_lp_exec_core
  import arm_lp_pkg::*;
#(
  parameter int DCACHE_ADDR_BITS = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] instruction,
  input  logic [31:0] read_data1,
  input  logic [31:0] read_data2,
  input  logic [31:0] store_data,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        branch,
  output logic        uncond_branch,
  output logic        alu_src,
  output logic [2:0]  op_type,
  output logic [3:0]  alu_control_code,
  output logic [4:0]  read_register1,
  output logic [4:0]  read_register2,
  output logic [4:0]  write_register,
  output logic [31:0] alu_result,
  output logic        zero_flag,
  output logic        carry_bit,
  output logic [31:0] read_data
);

  arm_lp_decoder u_decoder (
    .clock            (clock),
    .reset_n          (reset_n),
    .instruction      (instruction),
    .reg_write        (reg_write),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_to_reg       (mem_to_reg),
    .branch           (branch),
    .uncond_branch    (uncond_branch),
    .alu_src          (alu_src),
    .op_type          (op_type),
    .alu_control_code (alu_control_code),
    .read_register1   (read_register1),
    .read_register2   (read_register2),
    .write_register   (write_register)
  );

  // ALU: 33-bit add/subtract so the carry-out falls out as bit 32.
  logic [32:0] sum, diff;
  logic [31:0] alu_d;
  logic        carry_d;

  assign sum  = {1'b0, read_data1} + {1'b0, read_data2};
  assign diff = {1'b0, read_data1} + {1'b0, ~read_data2} + 33'd1;

  always_comb begin
    alu_d   = '0;
    carry_d = 1'b0;
    case (alu_control_code)
      ALU_AND:  alu_d = read_data1 & read_data2;
      ALU_ORR:  alu_d = read_data1 | read_data2;
      ALU_ADD:  {carry_d, alu_d} = sum;
      ALU_SUB:  {carry_d, alu_d} = diff;
      ALU_PASS: alu_d = read_data2;
      ALU_NOR:  alu_d = ~(read_data1 | read_data2);
      default:  alu_d = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      alu_result <= '0;
      zero_flag  <= 1'b0;
      carry_bit  <= 1'b0;
    end else begin
      alu_result <= alu_d;
      zero_flag  <= (alu_d == 32'd0);
      carry_bit  <= carry_d;
    end
  end

  arm_lp_dcache #(
    .ADDR_BITS (DCACHE_ADDR_BITS)
  ) u_dcache (
    .clock      (clock),
    .reset_n    (reset_n),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_to_reg (mem_to_reg),
    .store_data (store_data),
    .alu_result (alu_result),
    .read_data  (read_data)
  );

endmodule

// File: tb/tb_arm_lp_exec_core.sv
// Directed, table-driven bench for arm_lp_exec_core.
module tb_arm_lp_exec_core;

  logic        clock;
  logic        reset_n;
  logic [31:0] instruction, read_data1, read_data2, store_data;
  logic        reg_write, mem_read, mem_write, mem_to_reg, branch, uncond_branch, alu_src;
  logic [2:0]  op_type;
  logic [3:0]  alu_control_code;
  logic [4:0]  read_register1, read_register2, write_register;
  logic [31:0] alu_result, read_data;
  logic        zero_flag, carry_bit;

  int n_total = 0;
  int n_pass  = 0;

  localparam logic [31:0] BUBBLE = 32'h0000_0000;  // decodes as invalid

  arm_lp_exec_core #(.DCACHE_ADDR_BITS(8)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .instruction      (instruction),
    .read_data1       (read_data1),
    .read_data2       (read_data2),
    .store_data       (store_data),
    .reg_write        (reg_write),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_to_reg       (mem_to_reg),
    .branch           (branch),
    .uncond_branch    (uncond_branch),
    .alu_src          (alu_src),
    .op_type          (op_type),
    .alu_control_code (alu_control_code),
    .read_register1   (read_register1),
    .read_register2   (read_register2),
    .write_register   (write_register),
    .alu_result       (alu_result),
    .zero_flag        (zero_flag),
    .carry_bit        (carry_bit),
    .read_data        (read_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // flags = {reg_write, mem_read, mem_write, mem_to_reg, branch, uncond_branch, alu_src}
  typedef struct {
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [6:0]  flags;
    logic [2:0]  op;
    logic [3:0]  ctl;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic [4:0]  wr;
    logic [31:0] res;
    logic        zero;
    logic        carry;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [6:0] flags_now();
    return {reg_write, mem_read, mem_write, mem_to_reg, branch, uncond_branch, alu_src};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One instruction through all three stages, with bubbles behind it.
  task automatic run_vec(input string tag, input vec_t v);
    instruction = v.instr;
    tick();  // E0
    check({tag, " flags"}, 32'(flags_now()), 32'(v.flags));
    check({tag, " op_type"}, 32'(op_type), 32'(v.op));
    check({tag, " alu_ctl"}, 32'(alu_control_code), 32'(v.ctl));
    check({tag, " rr1"}, 32'(read_register1), 32'(v.rr1));
    check({tag, " rr2"}, 32'(read_register2), 32'(v.rr2));
    check({tag, " wr"}, 32'(write_register), 32'(v.wr));
    instruction = BUBBLE;
    read_data1  = v.a;
    read_data2  = v.b;
    store_data  = v.sd;
    tick();  // E1
    check({tag, " alu_result"}, alu_result, v.res);
    check({tag, " zero_flag"}, 32'(zero_flag), 32'(v.zero));
    check({tag, " carry_bit"}, 32'(carry_bit), 32'(v.carry));
    tick();  // E2
    check({tag, " read_data"}, read_data, v.rd);
  endtask

  initial begin
    vec_t v;
    //           instr          a             b             sd            flags       op    ctl      rr1   rr2   wr    res           z     c     rd
    vecs[0]  = '{32'h8B020023, 32'd5,        32'd7,        32'd0,        7'b1000000, 3'd0, 4'b0010, 5'd1, 5'd2, 5'd3, 32'd12,       1'b0, 1'b0, 32'd12};        // ADD
    vecs[1]  = '{32'hCB020023, 32'd9,        32'd9,        32'd0,        7'b1000000, 3'd0, 4'b0110, 5'd1, 5'd2, 5'd3, 32'd0,        1'b1, 1'b1, 32'd0};         // SUB equal
    vecs[2]  = '{32'hAA020023, 32'hF0,       32'h0F,       32'd0,        7'b1000000, 3'd0, 4'b0001, 5'd1, 5'd2, 5'd3, 32'hFF,       1'b0, 1'b0, 32'hFF};        // ORR
    vecs[3]  = '{32'h8A020023, 32'hF0,       32'h0F,       32'd0,        7'b1000000, 3'd0, 4'b0000, 5'd1, 5'd2, 5'd3, 32'd0,        1'b1, 1'b0, 32'd0};         // AND
    vecs[4]  = '{32'h91000441, 32'hFFFFFFFF, 32'd1,        32'd0,        7'b1000001, 3'd1, 4'b0010, 5'd2, 5'd0, 5'd1, 32'd0,        1'b1, 1'b1, 32'd0};         // ADDI wrap
    vecs[5]  = '{32'hD1000441, 32'd3,        32'd5,        32'd0,        7'b1000001, 3'd1, 4'b0110, 5'd2, 5'd0, 5'd1, 32'hFFFFFFFE, 1'b0, 1'b0, 32'hFFFFFFFE};  // SUBI borrow
    vecs[6]  = '{32'hF8000022, 32'h10,       32'd0,        32'hDEADBEEF, 7'b0010001, 3'd2, 4'b0010, 5'd1, 5'd2, 5'd2, 32'h10,       1'b0, 1'b0, 32'h10};        // STUR
    vecs[7]  = '{32'hF8400022, 32'h10,       32'd0,        32'hDEADBEEF, 7'b1101001, 3'd2, 4'b0010, 5'd1, 5'd0, 5'd2, 32'h10,       1'b0, 1'b0, 32'hDEADBEEF};  // LDUR
    vecs[8]  = '{32'hB4000040, 32'h55,       32'd0,        32'd0,        7'b0000100, 3'd4, 4'b0111, 5'd2, 5'd0, 5'd0, 32'd0,        1'b1, 1'b0, 32'd0};         // CBZ taken
    vecs[9]  = '{32'hB4000040, 32'h55,       32'd3,        32'd0,        7'b0000100, 3'd4, 4'b0111, 5'd2, 5'd0, 5'd0, 32'd3,        1'b0, 1'b0, 32'd3};         // CBZ not taken
    vecs[10] = '{32'h14000004, 32'd6,        32'd3,        32'd0,        7'b0000010, 3'd3, 4'b0000, 5'd0, 5'd0, 5'd4, 32'd2,        1'b0, 1'b0, 32'd2};         // B
    vecs[11] = '{32'hFFFFFFFF, 32'hF0,       32'h0F,       32'd0,        7'b0000000, 3'd7, 4'b0000, 5'd0, 5'd0, 5'd0, 32'd0,        1'b1, 1'b0, 32'd0};         // invalid

    instruction = BUBBLE;
    read_data1  = '0;
    read_data2  = '0;
    store_data  = '0;
    reset_n     = 1'b1;
    #2 reset_n  = 1'b0;
    #20 reset_n = 1'b1;
    #1;
    check("reset op_type", 32'(op_type), 32'd0);
    check("reset flags", 32'(flags_now()), 32'd0);
    check("reset alu_result", alu_result, 32'd0);
    check("reset read_data", read_data, 32'd0);

    foreach (vecs[i]) run_vec($sformatf("v%0d", i), vecs[i]);

    // Back-to-back store then load to the same word.
    instruction = 32'hF8000022;
    tick();
    instruction = 32'hF8400022;
    read_data1  = 32'h20;
    read_data2  = 32'd0;
    store_data  = 32'h12345678;
    tick();
    check("b2b stur alu_result", alu_result, 32'h20);
    instruction = BUBBLE;
    store_data  = 32'd0;
    tick();
    check("b2b stur read_data", read_data, 32'h20);
    tick();
    check("b2b ldur read_data", read_data, 32'h12345678);

    // Reset arriving after a store's E1: store is dropped, cache cleared.
    instruction = 32'hF8000022;
    tick();
    instruction = BUBBLE;
    read_data1  = 32'h30;
    read_data2  = 32'd0;
    store_data  = 32'hCAFEF00D;
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("async rst alu_result", alu_result, 32'd0);
    check("async rst read_data", read_data, 32'd0);
    check("async rst op_type", 32'(op_type), 32'd0);
    check("async rst flags", 32'(flags_now()), 32'd0);
    check("async rst zero_flag", 32'(zero_flag), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    v = '{32'hF8400022, 32'h30, 32'd0, 32'd0, 7'b1101001, 3'd2, 4'b0010, 5'd1, 5'd0, 5'd2, 32'h30, 1'b0, 1'b0, 32'd0};
    run_vec("post-rst ld 0x30", v);
    v.a   = 32'h10;
    v.res = 32'h10;
    run_vec("post-rst ld 0x10", v);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
